// File: rtl/spi_pkg.sv
// Shared types and sizing for the SPI master transfer sequencer.
package spi_pkg;

  localparam int SPI_BITS  = 8;
  localparam int SPI_DIV_W = 8;
  localparam int SPI_EDGES = 2 * SPI_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Register-side control bundle of the SPI transfer sequencer.
interface spi_master_ctrl_if #(
  parameter int DIV_W = 8,
  parameter int BITS  = 8
);
  // Handshake: start is a level request, sampled only when the sequencer can
  // take it (IDLE, or the HOLD terminal cycle in burst builds); it is dropped,
  // never queued, otherwise. busy is high from the accepting edge to the end
  // of the transfer. done is a one-cycle pulse, and rx_data is valid from the
  // done cycle until the next done.
  logic              spi_en;
  logic              start;
  logic              cpol;
  logic              cpha;
  logic [DIV_W-1:0]  baud_div;
  logic              busy;
  logic              done;
  logic [BITS-1:0]   rx_data;
  spi_pkg::spi_state_e state;

  modport master (
    output spi_en, start, cpol, cpha, baud_div,
    input  busy, done, rx_data, state
  );

  modport slave (
    input  spi_en, start, cpol, cpha, baud_div,
    output busy, done, rx_data, state
  );
endinterface

// File: rtl/spi_clk_div.sv
// Baud divider: SCLK half-period timing, internal clock level and edge strobes.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W,
  parameter int EDGES = SPI_EDGES
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             tog_en,
  input  logic             cpha,
  input  logic [DIV_W-1:0] div,
  output logic             tc,
  output logic             last_edge,
  output logic             sck_i,
  output logic             pos_ev,
  output logic             neg_ev
);
  localparam int EW = $clog2(EDGES + 1);

  logic [DIV_W-1:0] cnt_q;
  logic [EW-1:0]    edge_q;
  logic             toggle;

  assign tc        = cnt_en && (cnt_q == div);
  assign last_edge = (edge_q == EW'(EDGES));
  assign toggle    = tc && tog_en && !last_edge;

  // Strobes register together with the toggle so they line up with sck_i.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q  <= '0;
      edge_q <= '0;
      sck_i  <= 1'b0;
      pos_ev <= 1'b0;
      neg_ev <= 1'b0;
    end else if (clr) begin
      cnt_q  <= '0;
      edge_q <= '0;
      sck_i  <= 1'b0;
      pos_ev <= 1'b0;
      neg_ev <= 1'b0;
    end else begin
      pos_ev <= toggle && !sck_i && !(cpha && (edge_q == '0));
      neg_ev <= toggle && sck_i;
      if (cnt_en) begin
        cnt_q <= tc ? '0 : cnt_q + 1'b1;
      end
      if (toggle) begin
        sck_i  <= ~sck_i;
        edge_q <= edge_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI transfer sequencer: SCLK generation, slave select, shifter controls, done.
// Define SPI_BURST_EN to chain back-to-back bytes under one slave select.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W,
  parameter int BITS  = SPI_BITS
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  spi_master_ctrl_if.slave bus,
  input  logic [BITS-1:0]  rx_shift,
  output logic             sclk,
  output logic             ss_n,
  output logic             load_tx_reg,
  output logic             enable,
  output logic             posedge_sclk_event,
  output logic             negedge_sclk_event
);
  logic [1:0]       state_q, state_d;
  logic             cpol_q, cpha_q;
  logic [DIV_W-1:0] div_q;
  logic [BITS-1:0]  rx_q;
  logic             ss_n_q, busy_q, load_q, done_q;
  logic             tc, last_edge, sck_i, clr, restart, accept, finish;

`ifdef SPI_BURST_EN
  assign restart = bus.start;
`else
  assign restart = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_SETUP;
      ST_SETUP: if (tc) state_d = ST_XFER;
      // Leave XFER one cycle after the last toggle so its strobe sees enable.
      ST_XFER:  if (last_edge) state_d = ST_HOLD;
      ST_HOLD:  if (tc) state_d = restart ? ST_SETUP : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (!bus.spi_en) state_d = ST_IDLE;
  end

  assign accept = bus.spi_en &&
                  (((state_q == ST_IDLE) && bus.start) ||
                   ((state_q == ST_HOLD) && tc && restart));
  assign finish = bus.spi_en && (state_q == ST_HOLD) && tc;
  assign clr    = (state_d != state_q) || (state_q == ST_IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      ss_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      ss_n_q  <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
      load_q  <= accept;
      done_q  <= finish;
      if (finish) rx_q <= rx_shift;
      if (accept) begin
        cpol_q <= bus.cpol;
        cpha_q <= bus.cpha;
        div_q  <= bus.baud_div;
      end
    end
  end

  spi_clk_div #(
    .DIV_W (DIV_W),
    .EDGES (2 * BITS)
  ) u_clk_div (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .clr       (clr),
    .cnt_en    (state_q != ST_IDLE),
    .tog_en    (state_q == ST_XFER),
    .cpha      (cpha_q),
    .div       (div_q),
    .tc        (tc),
    .last_edge (last_edge),
    .sck_i     (sck_i),
    .pos_ev    (posedge_sclk_event),
    .neg_ev    (negedge_sclk_event)
  );

  // Idle level follows the live cpol so the pad settles before a transfer.
  assign sclk        = sck_i ^ ((state_q == ST_IDLE) ? bus.cpol : cpol_q);
  assign ss_n        = ss_n_q;
  assign load_tx_reg = load_q;
  assign enable      = (state_q == ST_XFER);
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;
  assign bus.state   = spi_state_e'(state_q);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl; burst expectations follow SPI_BURST_EN.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int DIV_W = 8;
  localparam int BITS  = 8;

  logic             PCLK = 1'b0;
  logic             PRESETn;
  logic [BITS-1:0]  rx_shift;
  logic             sclk, ss_n, load_tx_reg, enable;
  logic             posedge_sclk_event, negedge_sclk_event;

  spi_master_ctrl_if #(.DIV_W(DIV_W), .BITS(BITS)) bus ();

  spi_master_ctrl #(.DIV_W(DIV_W), .BITS(BITS)) dut (
    .PCLK               (PCLK),
    .PRESETn            (PRESETn),
    .bus                (bus),
    .rx_shift           (rx_shift),
    .sclk               (sclk),
    .ss_n               (ss_n),
    .load_tx_reg        (load_tx_reg),
    .enable             (enable),
    .posedge_sclk_event (posedge_sclk_event),
    .negedge_sclk_event (negedge_sclk_event)
  );

  // clock/reset
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  int cyc, n_pos, n_neg, n_load, n_done, n_tog, n_en, last_tog, half_min, half_max;
  int lat, n_ss_hi, d2;
  logic prev_sclk;
  logic [BITS-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    cyc = 0; n_pos = 0; n_neg = 0; n_load = 0; n_done = 0; n_tog = 0; n_en = 0;
    last_tog = 0; half_min = 1000; half_max = 0; prev_sclk = sclk;
  endtask

  // Advance one PCLK and sample everything on the following falling edge.
  task automatic step();
    int half;
    @(negedge PCLK);
    cyc++;
    if (posedge_sclk_event) n_pos++;
    if (negedge_sclk_event) n_neg++;
    if (load_tx_reg) n_load++;
    if (bus.done) n_done++;
    if (enable) n_en++;
    if (sclk !== prev_sclk) begin
      if (n_tog > 0) begin
        half = cyc - last_tog;
        if (half < half_min) half_min = half;
        if (half > half_max) half_max = half;
      end
      n_tog++;
      last_tog = cyc;
    end
    prev_sclk = sclk;
  endtask

  // driver: one full transfer with optional mid-transfer start/cpol noise
  task automatic xfer(input logic pol, input logic pha, input logic [DIV_W-1:0] div,
                      input logic [BITS-1:0] rx, input bit disturb,
                      input int exp_lat, input int exp_pos, input int exp_en);
    int l;
    bus.cpol = pol; bus.cpha = pha; bus.baud_div = div; rx_shift = rx; bus.spi_en = 1'b1;
    #1;
    clr_counts();
    exp_q.push_back(rx);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("ss_n_after_start", ss_n, 0);
    chk("load_pulse", load_tx_reg, 1);
    chk("busy_set", bus.busy, 1);
    l = 0;
    while (!bus.done && l < 200) begin
      step();
      l++;
      if (disturb && l == 10) begin bus.start = 1'b1; bus.cpol = ~pol; end
      if (disturb && l == 14) begin bus.start = 1'b0; bus.cpol = pol; end
    end
    chk("latency", l, exp_lat);
    if (exp_q.size() > 0) chk("rx_data", bus.rx_data, exp_q.pop_front());
    chk("pos_strobes", n_pos, exp_pos);
    chk("neg_strobes", n_neg, BITS);
    chk("sclk_toggles", n_tog, 2 * BITS);
    chk("enable_cycles", n_en, exp_en);
    chk("load_count", n_load, 1);
    step();
    chk("done_single_cycle", bus.done, 0);
    chk("ss_n_released", ss_n, 1);
    chk("busy_cleared", bus.busy, 0);
    repeat (2) step();
    chk("done_count", n_done, 1);
  endtask

  initial begin
    PRESETn = 1'b0;
    bus.spi_en = 1'b0; bus.start = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0;
    bus.baud_div = '0; rx_shift = '0;
    #12;
    chk("rst_sclk", sclk, 0);
    chk("rst_ss_n", ss_n, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_load", load_tx_reg, 0);
    chk("rst_enable", enable, 0);
    chk("rst_pos_ev", posedge_sclk_event, 0);
    chk("rst_neg_ev", negedge_sclk_event, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_state", bus.state, IDLE);
    bus.cpol = 1'b1;
    #1;
    chk("rst_sclk_cpol1", sclk, 1);
    bus.cpol = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    bus.spi_en = 1'b1;
    step();

    // mode 0, fastest clock: 18*(0+1)+1 = 19
    xfer(1'b0, 1'b0, 8'd0, 8'h3C, 1'b0, 19, 8, 17);

    // mode 3, baud_div=3: 18*4+1 = 73, first posedge strobe suppressed
    bus.cpol = 1'b1;
    #1;
    chk("mode3_idle_sclk", sclk, 1);
    xfer(1'b1, 1'b1, 8'd3, 8'hA5, 1'b0, 73, 7, 65);
    chk("mode3_half_min", half_min, 4);
    chk("mode3_half_max", half_max, 4);
    chk("mode3_sclk_after", sclk, 1);
    bus.cpol = 1'b0;

    // mode 1, baud_div=1, start and cpol wiggled mid-transfer: 18*2+1 = 37
    xfer(1'b0, 1'b1, 8'd1, 8'h5A, 1'b1, 37, 7, 33);

    // spi_en dropped right after the fifth edge strobe
    bus.baud_div = 8'd0; bus.cpha = 1'b0; rx_shift = 8'hFF;
    #1;
    clr_counts();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 0;
    while ((n_pos + n_neg) < 5 && lat < 40) begin step(); lat++; end
    chk("edges_before_drop", n_pos + n_neg, 5);
    bus.spi_en = 1'b0;
    step();
    chk("drop_state", bus.state, IDLE);
    chk("drop_ss_n", ss_n, 1);
    chk("drop_enable", enable, 0);
    chk("drop_busy", bus.busy, 0);
    repeat (4) step();
    chk("drop_no_done", n_done, 0);
    chk("drop_rx_kept", bus.rx_data, 8'h5A);

    // start ignored while disabled
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_disabled_busy", bus.busy, 0);
    chk("start_disabled_ss_n", ss_n, 1);

    // start and spi_en rise together (spi_en is low here)
    xfer(1'b0, 1'b0, 8'd0, 8'hE7, 1'b0, 19, 8, 17);

    // asynchronous reset in the middle of XFER
    bus.baud_div = 8'd2; rx_shift = 8'h11;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    chk("pre_reset_enable", enable, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("arst_ss_n", ss_n, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_enable", enable, 0);
    chk("arst_sclk", sclk, 0);
    chk("arst_load", load_tx_reg, 0);
    chk("arst_pos_ev", posedge_sclk_event, 0);
    chk("arst_neg_ev", negedge_sclk_event, 0);
    chk("arst_rx_data", bus.rx_data, 0);
    chk("arst_state", bus.state, IDLE);
    @(negedge PCLK);
    PRESETn = 1'b1;
    xfer(1'b0, 1'b0, 8'd0, 8'hC3, 1'b0, 19, 8, 17);

    // start held through HOLD: burst chains, otherwise ss_n rises one cycle
    bus.baud_div = 8'd0; rx_shift = 8'h69;
    #1;
    clr_counts();
    exp_q.push_back(8'h69);
    exp_q.push_back(8'h96);
    bus.start = 1'b1;
    step();
    lat = 0; n_ss_hi = 0; d2 = 0;
    while (n_done < 2 && lat < 100) begin
      step();
      lat++;
      if (bus.done) begin
        if (exp_q.size() > 0) chk("chain_rx", bus.rx_data, exp_q.pop_front());
        rx_shift = 8'h96;
        d2 = lat;
      end
      if (ss_n && n_done == 1) n_ss_hi++;
      if (n_load == 2) bus.start = 1'b0;
    end
    chk("chain_done_count", n_done, 2);
    chk("chain_load_count", n_load, 2);
`ifdef SPI_BURST_EN
    chk("chain_ss_n_high_cycles", n_ss_hi, 0);
    chk("chain_second_done", d2, 38);
`else
    chk("chain_ss_n_high_cycles", n_ss_hi, 1);
    chk("chain_second_done", d2, 39);
`endif
    bus.start = 1'b0;
    repeat (3) step();
    chk("chain_end_ss_n", ss_n, 1);
    chk("chain_end_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
